// File: rtl/rr_arbiter3.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter3
//  Purpose  : Three-requester round-robin arbiter for a single shared
//             resource. Grants one requester, strobes the resource, waits
//             for completion (or a timeout) and reports done/err back.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter3 #(
    parameter int BITS    = 1,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [2:0]      req,
    input  logic [BITS-1:0] data0,
    input  logic [BITS-1:0] data1,
    input  logic [BITS-1:0] data2,
    input  logic            res_done,
    output logic [2:0]      gnt,
    output logic [2:0]      done,
    output logic [2:0]      err,
    output logic            res_start,
    output logic [BITS-1:0] res_data,
    output logic            busy
);

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [1:0]      r_ptr;
    logic [1:0]      r_idx;
    logic [7:0]      r_cnt;
    logic [2:0]      r_gnt;
    logic [2:0]      r_done;
    logic [2:0]      r_err;
    logic [BITS-1:0] r_data;

    logic            w_found;
    logic [1:0]      w_win;
    logic [1:0]      w_c0;
    logic [1:0]      w_c1;
    logic [1:0]      w_c2;
    logic            w_timeout;

    // Pointer only ever holds 0..2, so the wrap is explicit rather than a modulo.
    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    function automatic logic req_at(input logic [2:0] r, input logic [1:0] i);
        case (i)
            2'd0:    return r[0];
            2'd1:    return r[1];
            2'd2:    return r[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        case (i)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Round-robin scan starting at the pointer; first set request wins.
    always_comb begin
        w_c0    = r_ptr;
        w_c1    = inc3(w_c0);
        w_c2    = inc3(w_c1);
        w_found = 1'b1;
        w_win   = w_c0;
        if (req_at(req, w_c0)) begin
            w_win = w_c0;
        end else if (req_at(req, w_c1)) begin
            w_win = w_c1;
        end else if (req_at(req, w_c2)) begin
            w_win = w_c2;
        end else begin
            w_found = 1'b0;
        end
    end

    // Timeout fires on the WAIT cycle in which the counter would reach TIMEOUT.
    assign w_timeout = ((r_cnt + 8'd1) == c_TIMEOUT);

    // Next-state logic; res_done takes priority over the timeout in WAIT.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_found) w_next_state = S_START;
            S_START:  w_next_state = S_WAIT;
            S_WAIT:   if (res_done || w_timeout) w_next_state = S_FINISH;
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Grant/payload latching, wait counter, completion flags and pointer update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr  <= 2'd0;
            r_idx  <= 2'd0;
            r_cnt  <= 8'd0;
            r_gnt  <= 3'b000;
            r_done <= 3'b000;
            r_err  <= 3'b000;
            r_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx <= w_win;
                        r_gnt <= onehot(w_win);
                        case (w_win)
                            2'd0:    r_data <= data0;
                            2'd1:    r_data <= data1;
                            default: r_data <= data2;
                        endcase
                    end
                end
                S_START: begin
                    r_cnt <= 8'd0;
                end
                S_WAIT: begin
                    if (res_done)       r_done <= r_gnt;
                    else if (w_timeout) r_err  <= r_gnt;
                    else                r_cnt  <= r_cnt + 8'd1;
                end
                S_FINISH: begin
                    r_done <= 3'b000;
                    r_err  <= 3'b000;
                    r_gnt  <= 3'b000;
                    r_data <= '0;
                    r_ptr  <= inc3(r_idx);
                end
                default: ;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign res_data  = r_data;
    assign res_start = (r_state == S_START);
    assign busy      = (r_state != S_IDLE);

`ifdef FORMAL
    // Strobe confinement, one-hot-or-zero outputs and busy consistency.
    always_comb begin
        assert (done == 3'b000 || r_state == S_FINISH);
        assert (err == 3'b000 || r_state == S_FINISH);
        assert (!res_start || r_state == S_START);
        assert ((gnt & (gnt - 3'd1)) == 3'b000);
        assert ((done & (done - 3'd1)) == 3'b000);
        assert ((err & (err - 3'd1)) == 3'b000);
        assert (busy == (r_state != S_IDLE));
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter3.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_arbiter3
//  Purpose  : Directed self-checking bench for rr_arbiter3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter3;

    localparam int c_BITS    = 4;
    localparam int c_TIMEOUT = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2:0]        req;
    logic [c_BITS-1:0] data0, data1, data2;
    logic              res_done;
    logic [2:0]        gnt, done, err;
    logic              res_start;
    logic [c_BITS-1:0] res_data;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter3 #(.BITS(c_BITS), .TIMEOUT(c_TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .res_done  (res_done),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .res_start (res_start),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_data(input logic [2:0] g);
        case (g)
            3'b001:  return 8'd3;
            3'b010:  return 8'd5;
            3'b100:  return 8'd9;
            default: return 8'd0;
        endcase
    endfunction

    // One full operation: IDLE sample -> START -> nwait WAIT cycles -> FINISH -> IDLE.
    task automatic do_op(input string nm, input logic [2:0] r, input logic [2:0] eg,
                         input int nwait, input bit use_done, input bit drop);
        req = r;
        step();
        check({nm, ".start.gnt"},   8'(gnt), 8'(eg));
        check({nm, ".start.rs"},    8'(res_start), 8'd1);
        check({nm, ".start.data"},  8'(res_data), exp_data(eg));
        check({nm, ".start.busy"},  8'(busy), 8'd1);
        step();
        check({nm, ".wait.rs"},     8'(res_start), 8'd0);
        if (drop) req = 3'b000;
        for (int i = 1; i < nwait; i++) begin
            check({nm, ".wait.de"}, 8'({done, err}), 8'd0);
            step();
        end
        check({nm, ".wait.gnt"},    8'(gnt), 8'(eg));
        res_done = use_done;
        step();
        res_done = 1'b0;
        check({nm, ".fin.done"},    8'(done), use_done ? 8'(eg) : 8'd0);
        check({nm, ".fin.err"},     8'(err),  use_done ? 8'd0 : 8'(eg));
        check({nm, ".fin.gnt"},     8'(gnt), 8'(eg));
        check({nm, ".fin.data"},    8'(res_data), exp_data(eg));
        step();
        check({nm, ".idle.gnt"},    8'(gnt), 8'd0);
        check({nm, ".idle.de"},     8'({done, err}), 8'd0);
        check({nm, ".idle.busy"},   8'(busy), 8'd0);
        check({nm, ".idle.data"},   8'(res_data), 8'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = 3'b000;
        data0    = 4'd3;
        data1    = 4'd5;
        data2    = 4'd9;
        res_done = 1'b0;
        #2;
        check("rst.gnt",  8'(gnt), 8'd0);
        check("rst.done", 8'(done), 8'd0);
        check("rst.err",  8'(err), 8'd0);
        check("rst.rs",   8'(res_start), 8'd0);
        check("rst.data", 8'(res_data), 8'd0);
        check("rst.busy", 8'(busy), 8'd0);
        step();
        reset_n = 1'b1;
        step();
        check("idle.busy", 8'(busy), 8'd0);

        // Single request, completion on the second WAIT cycle; ptr becomes 2.
        do_op("single", 3'b010, 3'b010, 2, 1'b1, 1'b0);
        // ptr==2 check: 101 from ptr 2 picks requester 2; ptr becomes 0.
        do_op("ptr2", 3'b101, 3'b100, 1, 1'b1, 1'b0);
        // Fairness with all requests held from ptr 0.
        do_op("fair0", 3'b111, 3'b001, 1, 1'b1, 1'b0);
        do_op("fair1", 3'b111, 3'b010, 1, 1'b1, 1'b0);
        do_op("fair2", 3'b111, 3'b100, 1, 1'b1, 1'b0);
        do_op("fair3", 3'b111, 3'b001, 1, 1'b1, 1'b0);
        // Timeout after TIMEOUT WAIT cycles; ptr becomes 1.
        do_op("tmo", 3'b001, 3'b001, c_TIMEOUT, 1'b0, 1'b0);
        // ptr==1 after timeout, and res_done on the timeout cycle wins.
        do_op("tie", 3'b111, 3'b010, c_TIMEOUT, 1'b1, 1'b0);
        // Early drop of the request: operation still completes; ptr becomes 1.
        do_op("drop", 3'b001, 3'b001, 2, 1'b1, 1'b1);

        // Reset mid-WAIT: ptr is 1, so 100 wins.
        req = 3'b100;
        step();
        check("mrst.start.gnt", 8'(gnt), 8'b100);
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst.gnt",  8'(gnt), 8'd0);
        check("mrst.busy", 8'(busy), 8'd0);
        check("mrst.data", 8'(res_data), 8'd0);
        check("mrst.de",   8'({done, err, res_start}), 8'd0);
        step();
        check("mrst.held.de", 8'({done, err}), 8'd0);
        reset_n = 1'b1;
        req     = 3'b101;
        step();
        check("post.gnt",  8'(gnt), 8'b001);
        check("post.data", 8'(res_data), 8'd3);
        check("post.done", 8'(done), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
